stream_header_encoder: RTL and testbench
========================================

Name: stream_header_encoder

Overview:
- Transmit-side counterpart of the camera header decode path.
- Accepts one stream parameter set on a `start` strobe and checks it against the same legality rules the decoder enforces.
- A legal set is serialized into a byte-wide header: start code, packed fields and an optional checksum. Output uses a valid/ready handshake.
- Sits in the encoder/loopback-test path, ahead of the byte packer that feeds the link.

Parameters:
- SC_LEN, 3, start-code length in bytes (legal 2..4): SC_LEN-1 bytes of 0x00 followed by 0x01.
- MAX_QP, 51, largest legal qp value.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- profile  in  8  stream profile
- width  in  16  frame width in pixels
- height  in  16  frame height in pixels
- fps  in  8  frame rate
- chroma_format  in  2  chroma format code
- bit_depth  in  4  sample bit depth
- qp  in  6  quantisation parameter
- tiles_enabled  in  1  tiles enable
- tile_cols  in  4  tile columns
- tile_rows  in  4  tile rows
- out_data  out  8  header byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts byte
- out_last  out  1  marks the final header byte
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when a request finishes (success or reject)
- err  out  1  one-cycle pulse, coincident with done, when the parameter set is rejected

Behaviour:
- Reset (async): state=IDLE. out_data=0, out_valid=0, out_last=0, busy=0, done=0, err=0, byte index=0.
  - Reset during SEND abandons the frame. Nothing resumes after reset.
- States: IDLE, CHECK, SEND.
- IDLE, start=1: latch all parameter inputs into holding registers and go to CHECK.
  - Inputs are don't-care after this edge.
  - start is ignored while busy.
- CHECK, one cycle. The set is legal only if all of the following hold:
  - profile is 1 or 2
  - width[3:0]==0 and height[3:0]==0
  - qp <= MAX_QP
  - chroma_format==1
  - bit_depth is 8 or 10
  - fps != 0
  - if tiles_enabled: tile_cols != 0 and tile_rows != 0
- CHECK, illegal: go to IDLE with err=1 and done=1 for exactly one cycle. No byte is emitted.
- CHECK, legal: go to SEND with out_valid=1, out_data=byte0, index=0.
  - First out_valid is seen 2 cycles after the start edge.
- Byte order (N = SC_LEN+9 bytes without checksum):
  - start code
  - P0 profile
  - P1 width[15:8], P2 width[7:0]
  - P3 height[15:8], P4 height[7:0]
  - P5 fps
  - P6 {chroma_format, bit_depth, tiles_enabled, 1'b0}
  - P7 {qp, 2'b00}
  - P8 {tile_cols, tile_rows}
  - checksum (feature dependent)
- SEND: a byte transfers on a cycle with out_valid && out_ready. After a transfer the next byte is presented in the next cycle, so the block sustains one byte per cycle under constant ready.
- While out_valid && !out_ready: out_data and out_last hold stable and out_valid stays high.
  - out_valid never drops mid-frame.
  - No timeout.
- out_last is high only while the final byte is presented.
- Final transfer: go to IDLE with out_valid=0, out_last=0 and done=1 for one cycle (err=0).
  - A new start is accepted in that same IDLE cycle.
- Fields are packed zero-extended with no arithmetic; the checksum is an 8-bit XOR.

Optional Feature:
- HDR_CHECKSUM_EN defined:
  - One extra byte follows P8 and carries out_last. Total is SC_LEN+10 bytes.
  - The byte is XOR of P0..P8, computed from the holding registers during CHECK and registered.
- HDR_CHECKSUM_EN undefined:
  - No checksum byte; P8 carries out_last. Total is SC_LEN+9 bytes.
  - No checksum logic is present.

Test Plan:
- Legal set: profile 1, width 1920, height 1088, fps 30, chroma 1, bit_depth 8, qp 26, tiles 0, out_ready=1.
  - Required stream: 00 00 01 01 07 80 04 40 1E 60 68 00, then D4 with HDR_CHECKSUM_EN.
  - out_last on the final byte, done one cycle after, err=0.
- Same set with width 1918 -> err=1 and done=1 exactly 2 cycles after the start edge, out_valid never asserted, busy low afterwards.
- Each single-rule violation in turn -> err pulse, no bytes:
  - profile 3
  - qp 52
  - chroma 2
  - bit_depth 12
  - fps 0
  - tiles_enabled=1 with tile_cols 0
- Legal set with out_ready toggling 1,0,0,1 repeatedly -> byte sequence identical to the first test, out_data stable during stalls, no dropped or duplicated bytes.
- start pulsed again during SEND -> ignored, single frame emitted. start on the done cycle -> second frame begins correctly.
- reset asserted mid-SEND after byte 5 -> out_valid=0 and busy=0 immediately. A new start then produces a complete frame from byte0.

Source files
------------

// File: rtl/stream_header_encoder.sv
// stream_header_encoder: latches one stream parameter set on start, checks it
// against the decoder's legality rules and serializes a legal set as a
// byte-wide header (start code, packed fields, optional XOR checksum) over a
// valid/ready handshake.
// Optional feature macro: HDR_CHECKSUM_EN appends an XOR checksum byte after P8.
module stream_header_encoder #(
  parameter int SC_LEN = 3,
  parameter int MAX_QP = 51
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  profile,
  input  logic [15:0] width,
  input  logic [15:0] height,
  input  logic [7:0]  fps,
  input  logic [1:0]  chroma_format,
  input  logic [3:0]  bit_depth,
  input  logic [5:0]  qp,
  input  logic        tiles_enabled,
  input  logic [3:0]  tile_cols,
  input  logic [3:0]  tile_rows,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, CHECK, SEND} state_t;

`ifdef HDR_CHECKSUM_EN
  localparam int N_BYTES = SC_LEN + 10;
`else
  localparam int N_BYTES = SC_LEN + 9;
`endif
  localparam logic [3:0] LAST_IDX = 4'(N_BYTES - 1);

  state_t      state;
  logic [3:0]  idx;

  logic [7:0]  h_profile;
  logic [15:0] h_width;
  logic [15:0] h_height;
  logic [7:0]  h_fps;
  logic [1:0]  h_chroma;
  logic [3:0]  h_bit_depth;
  logic [5:0]  h_qp;
  logic        h_tiles;
  logic [3:0]  h_cols;
  logic [3:0]  h_rows;
  logic        legal;
`ifdef HDR_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  // Packed parameter field k (P0..P8, plus checksum when enabled).
  function automatic logic [7:0] field_byte(input logic [3:0] k);
    logic [7:0] b;
    case (k)
      4'd0:    b = h_profile;
      4'd1:    b = h_width[15:8];
      4'd2:    b = h_width[7:0];
      4'd3:    b = h_height[15:8];
      4'd4:    b = h_height[7:0];
      4'd5:    b = h_fps;
      4'd6:    b = {h_chroma, h_bit_depth, h_tiles, 1'b0};
      4'd7:    b = {h_qp, 2'b00};
      4'd8:    b = {h_cols, h_rows};
`ifdef HDR_CHECKSUM_EN
      4'd9:    b = csum;
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Header byte at stream position i: start code first, then the fields.
  function automatic logic [7:0] hdr_byte(input logic [3:0] i);
    logic [7:0] b;
    if (int'(i) < SC_LEN - 1)
      b = 8'h00;
    else if (int'(i) == SC_LEN - 1)
      b = 8'h01;
    else
      b = field_byte(4'(int'(i) - SC_LEN));
    return b;
  endfunction

  // Legality rules shared with the decoder, evaluated on the held set.
  always_comb begin
    legal = 1'b1;
    if (!(h_profile == 8'd1 || h_profile == 8'd2))          legal = 1'b0;
    if (h_width[3:0] != 4'd0 || h_height[3:0] != 4'd0)      legal = 1'b0;
    if (int'(h_qp) > MAX_QP)                                legal = 1'b0;
    if (h_chroma != 2'd1)                                   legal = 1'b0;
    if (!(h_bit_depth == 4'd8 || h_bit_depth == 4'd10))     legal = 1'b0;
    if (h_fps == 8'd0)                                      legal = 1'b0;
    if (h_tiles && (h_cols == 4'd0 || h_rows == 4'd0))      legal = 1'b0;
  end

  // Capture the parameter set on an accepted start; inputs are free afterwards.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      h_profile   <= profile;
      h_width     <= width;
      h_height    <= height;
      h_fps       <= fps;
      h_chroma    <= chroma_format;
      h_bit_depth <= bit_depth;
      h_qp        <= qp;
      h_tiles     <= tiles_enabled;
      h_cols      <= tile_cols;
      h_rows      <= tile_rows;
    end
  end

`ifdef HDR_CHECKSUM_EN
  // Checksum is formed once in CHECK so SEND only indexes registers.
  always_ff @(posedge clk) begin
    if (state == CHECK)
      csum <= h_profile ^ h_width[15:8] ^ h_width[7:0] ^ h_height[15:8] ^
              h_height[7:0] ^ h_fps ^ {h_chroma, h_bit_depth, h_tiles, 1'b0} ^
              {h_qp, 2'b00} ^ {h_cols, h_rows};
  end
`endif

  // Control FSM: accept, check, then stream bytes under the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      idx       <= 4'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CHECK;
            busy  <= 1'b1;
          end
        end
        CHECK: begin
          if (legal) begin
            state     <= SEND;
            out_valid <= 1'b1;
            out_data  <= hdr_byte(4'd0);
            out_last  <= 1'b0;
            idx       <= 4'd0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              idx       <= 4'd0;
            end else begin
              idx      <= idx + 4'd1;
              out_data <= hdr_byte(idx + 4'd1);
              out_last <= ((idx + 4'd1) == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_header_encoder.sv
// Self-checking bench for stream_header_encoder: expected header bytes are
// queued when a request is issued and compared as the DUT transfers them.
// Build with HDR_CHECKSUM_EN defined to cover the checksum variant.
module tb_stream_header_encoder;

  localparam int SC_LEN = 3;
`ifdef HDR_CHECKSUM_EN
  localparam int CS_EN = 1;
`else
  localparam int CS_EN = 0;
`endif

  typedef struct packed {
    logic [7:0]  profile;
    logic [15:0] width;
    logic [15:0] height;
    logic [7:0]  fps;
    logic [1:0]  chroma;
    logic [3:0]  bd;
    logic [5:0]  qp;
    logic        te;
    logic [3:0]  tc;
    logic [3:0]  tr;
  } hdr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  profile = '0;
  logic [15:0] width = '0;
  logic [15:0] height = '0;
  logic [7:0]  fps = '0;
  logic [1:0]  chroma_format = '0;
  logic [3:0]  bit_depth = '0;
  logic [5:0]  qp = '0;
  logic        tiles_enabled = 1'b0;
  logic [3:0]  tile_cols = '0;
  logic [3:0]  tile_rows = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_mis = 0;
  int xfer_cnt = 0;
  logic [8:0] q[$];
  bit ready_mode = 1'b0;
  int rk = 0;
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit prev_stall = 1'b0;
  bit pend_done = 1'b0;
  logic [7:0] hold_data = '0;
  logic       hold_last = 1'b0;
  logic [7:0] gold[13] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h07, 8'h80, 8'h04,
                           8'h40, 8'h1E, 8'h60, 8'h68, 8'h00, 8'hD4};

  stream_header_encoder #(.SC_LEN(SC_LEN), .MAX_QP(51)) dut (
    .clk(clk), .reset(reset), .start(start), .profile(profile),
    .width(width), .height(height), .fps(fps), .chroma_format(chroma_format),
    .bit_depth(bit_depth), .qp(qp), .tiles_enabled(tiles_enabled),
    .tile_cols(tile_cols), .tile_rows(tile_rows), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Downstream ready: constant high, or the 1,0,0,1 stall pattern.
  always @(posedge clk) begin
    #1;
    if (ready_mode) begin
      out_ready = pat[rk];
      rk = (rk + 1) % 4;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Output monitor: scoreboard pop on transfer, stall stability, done after last.
  always @(negedge clk) begin
    logic [8:0] e;
    if (reset) begin
      prev_stall = 1'b0;
      pend_done  = 1'b0;
    end else begin
      if (pend_done) begin
        chk("done_after_last", done, 1);
        chk("err_after_last", err, 0);
        chk("valid_after_last", out_valid, 0);
        pend_done = 1'b0;
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hold_data);
        chk("stall_last", out_last, hold_last);
      end
      prev_stall = out_valid && !out_ready;
      hold_data  = out_data;
      hold_last  = out_last;
      if (out_valid) chk("valid_expected", q.size() != 0, 1);
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("byte", out_data, e[7:0]);
        chk("last", out_last, e[8]);
        xfer_cnt++;
        if (out_last) pend_done = 1'b1;
      end
    end
  end

  function automatic hdr_t base_set();
    hdr_t p;
    p.profile = 8'd1;  p.width = 16'd1920; p.height = 16'd1088; p.fps = 8'd30;
    p.chroma = 2'd1;   p.bd = 4'd8;        p.qp = 6'd26;        p.te = 1'b0;
    p.tc = 4'd0;       p.tr = 4'd0;
    return p;
  endfunction

  task automatic push_golden();
    int n;
    n = SC_LEN + 9 + CS_EN;
    for (int i = 0; i < n; i++) q.push_back({(i == n - 1), gold[i]});
  endtask

  task automatic push_model(input hdr_t p);
    logic [7:0] f[10];
    logic [7:0] cs;
    int n;
    for (int i = 0; i < SC_LEN - 1; i++) q.push_back({1'b0, 8'h00});
    q.push_back({1'b0, 8'h01});
    f[0] = p.profile;      f[1] = p.width[15:8];  f[2] = p.width[7:0];
    f[3] = p.height[15:8]; f[4] = p.height[7:0];  f[5] = p.fps;
    f[6] = {p.chroma, p.bd, p.te, 1'b0};
    f[7] = {p.qp, 2'b00};
    f[8] = {p.tc, p.tr};
    cs = 8'h00;
    for (int i = 0; i < 9; i++) cs = cs ^ f[i];
    f[9] = cs;
    n = 9 + CS_EN;
    for (int i = 0; i < n; i++) q.push_back({(i == n - 1), f[i]});
  endtask

  task automatic drive(input hdr_t p);
    profile = p.profile; width = p.width; height = p.height; fps = p.fps;
    chroma_format = p.chroma; bit_depth = p.bd; qp = p.qp;
    tiles_enabled = p.te; tile_cols = p.tc; tile_rows = p.tr;
  endtask

  // Drive start for one cycle, then scramble inputs (don't-care after accept).
  task automatic send_start(input hdr_t p);
    hdr_t z;
    @(posedge clk); #1;
    drive(p);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    z = '0;
    drive(z);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_legal(input hdr_t p, input bit golden);
    bit ok;
    if (golden) push_golden(); else push_model(p);
    send_start(p);
    @(negedge clk);
    chk("check_busy", busy, 1);
    chk("check_novalid", out_valid, 0);
    @(negedge clk);
    chk("first_valid", out_valid, 1);
    wait_done(ok);
    chk("done_seen", ok, 1);
    chk("done_err", err, 0);
    chk("done_busy", busy, 0);
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic run_reject(input string tag, input hdr_t p);
    send_start(p);
    @(negedge clk);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_early_done"}, done, 0);
    @(negedge clk);
    chk({tag, "_err"}, err, 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_valid"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_err_pulse"}, err, 0);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    hdr_t p, p2;
    bit ok;

    #3;
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Golden legal frame with constant ready.
    run_legal(base_set(), 1'b1);

    // Single-rule violations.
    p = base_set(); p.width = 16'd1918;       run_reject("width", p);
    p = base_set(); p.profile = 8'd3;         run_reject("profile", p);
    p = base_set(); p.qp = 6'd52;             run_reject("qp", p);
    p = base_set(); p.chroma = 2'd2;          run_reject("chroma", p);
    p = base_set(); p.bd = 4'd12;             run_reject("bitdepth", p);
    p = base_set(); p.fps = 8'd0;             run_reject("fps", p);
    p = base_set(); p.te = 1'b1; p.tc = 4'd0; p.tr = 4'd2; run_reject("tiles", p);

    // Boundary-legal set via model: qp at MAX_QP, tiles on, profile 2, depth 10.
    p = base_set(); p.profile = 8'd2; p.qp = 6'd51; p.bd = 4'd10;
    p.te = 1'b1; p.tc = 4'd3; p.tr = 4'd5; p.width = 16'hABC0; p.fps = 8'd60;
    run_legal(p, 1'b0);

    // Stalled output: ready 1,0,0,1 repeating.
    ready_mode = 1'b1;
    run_legal(base_set(), 1'b1);
    ready_mode = 1'b0;
    repeat (2) @(negedge clk);

    // start during SEND ignored; start on the done cycle begins a new frame.
    p = base_set();
    push_golden();
    send_start(p);
    repeat (4) @(posedge clk);
    p2 = base_set(); p2.fps = 8'd99;
    send_start(p2);
    wait_done(ok);
    chk("resend_done", ok, 1);
    p2 = base_set(); p2.height = 16'd720; p2.qp = 6'd0;
    drive(p2);
    start = 1'b1;
    push_model(p2);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(ok);
    chk("chain_done", ok, 1);
    chk("chain_drained", q.size(), 0);
    repeat (3) @(negedge clk);
    chk("idle_quiet", out_valid, 0);

    // Reset mid-SEND after byte 5, then a full frame from byte0.
    xfer_cnt = 0;
    push_golden();
    send_start(base_set());
    for (int i = 0; i < 100 && xfer_cnt < 6; i++) @(negedge clk);
    chk("mid_bytes_reached", xfer_cnt >= 6, 1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_legal(base_set(), 1'b1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
